// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive datapath.
package usb_rx_pkg;

    localparam int USB_BYTE_BITS   = 8;
    localparam int USB_STUFF_LIMIT = 6;

    typedef logic [USB_BYTE_BITS-1:0] usb_byte_t;

endpackage

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register; receive-side counterpart of flex_pts_sr.
// SHIFT_MSB=1 shifts toward the MSB, so the first bit received ends up in the MSB.
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                clear,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] r_sr;

    // Shift one bit in per enable; a synchronous clear wins over a shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sr <= '0;
        end else if (clear) begin
            r_sr <= '0;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                r_sr <= {r_sr[NUM_BITS-2:0], serial_in};
            end else begin
                r_sr <= {serial_in, r_sr[NUM_BITS-1:1]};
            end
        end
    end

    assign parallel_out = r_sr;

endmodule

// File: rtl/rx_shift_register.sv
// USB RX serial-to-parallel stage: removes stuffed bits, assembles bytes MSB-first
// and hands them to the RX controller through a valid/ack holding register.
module rx_shift_register
    import usb_rx_pkg::*;
#(
    parameter int NUM_BITS    = USB_BYTE_BITS,
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                rx_bit,
    input  logic                shift_strobe,
    input  logic                packet_active,
    input  logic                byte_ack,
    output logic [NUM_BITS-1:0] rx_packet_data,
    output logic                byte_valid,
    output logic                stuff_error,
    output logic                overrun,
    output logic                partial_byte
);

    localparam int BIT_CW  = $clog2(NUM_BITS);
    localparam int ONES_CW = $clog2(STUFF_LIMIT + 1);

    localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(NUM_BITS - 1);
    localparam logic [ONES_CW-1:0] ONES_STOP = ONES_CW'(STUFF_LIMIT);

    logic                r_pa_d;
    logic [BIT_CW-1:0]   r_bit_count;
    logic [ONES_CW-1:0]  r_ones_count;
    logic [NUM_BITS-1:0] r_data;
    logic                r_valid;
    logic                r_stuff_error;
    logic                r_overrun;
    logic                r_partial;

    logic                w_clear;
    logic                w_strobe;
    logic                w_stuff_slot;
    logic                w_data_bit;
    logic                w_complete;
    logic [NUM_BITS-1:0] w_sr;
    logic [NUM_BITS-1:0] w_next_byte;
    // The shifter MSB is the bit that falls off when the final bit is appended.
    logic                w_unused_sr_msb;

    // Track packet_active so its falling edge can be detected.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pa_d <= 1'b0;
        end else begin
            r_pa_d <= packet_active;
        end
    end

    // Falling edge of packet_active clears assembly state; it also gates every strobe.
    assign w_clear      = r_pa_d & ~packet_active;
    assign w_strobe     = shift_strobe & packet_active & ~w_clear;
    assign w_stuff_slot = (r_ones_count == ONES_STOP);
    assign w_data_bit   = w_strobe & ~w_stuff_slot;
    assign w_complete   = w_data_bit & (r_bit_count == LAST_BIT);

    // Completed byte is the current partial byte with this strobe's bit appended.
    assign w_next_byte     = {w_sr[NUM_BITS-2:0], rx_bit};
    assign w_unused_sr_msb = w_sr[NUM_BITS-1];

    flex_stp_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (1'b1)
    ) u_stp_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (w_data_bit),
        .clear        (w_clear | w_complete),
        .serial_in    (rx_bit),
        .parallel_out (w_sr)
    );

    // Bit and run-of-ones counters; the ones run carries across byte boundaries.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_count  <= '0;
            r_ones_count <= '0;
        end else if (w_clear) begin
            r_bit_count  <= '0;
            r_ones_count <= '0;
        end else if (w_strobe) begin
            if (w_stuff_slot) begin
                r_ones_count <= '0;
            end else begin
                r_bit_count  <= w_complete ? '0 : r_bit_count + 1'b1;
                r_ones_count <= rx_bit ? r_ones_count + 1'b1 : '0;
            end
        end
    end

    // Sticky error flags and the end-of-packet partial-byte pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stuff_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_partial     <= 1'b0;
        end else begin
            r_partial <= w_clear & (r_bit_count != '0);
            if (w_clear) begin
                r_stuff_error <= 1'b0;
                r_overrun     <= 1'b0;
            end else begin
                if (w_strobe && w_stuff_slot && rx_bit) begin
                    r_stuff_error <= 1'b1;
                end
                if (w_complete && r_valid && !byte_ack) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // Holding register: an unacknowledged byte is kept and the new one dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || byte_ack) begin
                r_data  <= w_next_byte;
                r_valid <= 1'b1;
            end
        end else if (r_valid && byte_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign rx_packet_data = r_data;
    assign byte_valid     = r_valid;
    assign stuff_error    = r_stuff_error;
    assign overrun        = r_overrun;
    assign partial_byte   = r_partial;

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed test of rx_shift_register: byte assembly, bit destuffing, handshake,
// overrun, end-of-packet handling and asynchronous reset.
module tb_rx_shift_register;

    logic       clk;
    logic       n_rst;
    logic       rx_bit;
    logic       shift_strobe;
    logic       packet_active;
    logic       byte_ack;
    logic [7:0] rx_packet_data;
    logic       byte_valid;
    logic       stuff_error;
    logic       overrun;
    logic       partial_byte;

    int n_checks = 0;
    int n_errors = 0;

    rx_shift_register dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .rx_bit         (rx_bit),
        .shift_strobe   (shift_strobe),
        .packet_active  (packet_active),
        .byte_ack       (byte_ack),
        .rx_packet_data (rx_packet_data),
        .byte_valid     (byte_valid),
        .stuff_error    (stuff_error),
        .overrun        (overrun),
        .partial_byte   (partial_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_bit       = b;
        shift_strobe = 1'b1;
        @(posedge clk);
        #1;
        shift_strobe = 1'b0;
        rx_bit       = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack_last);
        for (int i = 7; i >= 0; i--) begin
            if (ack_last && i == 0) byte_ack = 1'b1;
            send_bit(b[i]);
            byte_ack = 1'b0;
        end
    endtask

    task automatic ack_byte();
        byte_ack = 1'b1;
        idle(1);
        byte_ack = 1'b0;
    endtask

    task automatic new_packet();
        packet_active = 1'b0;
        idle(2);
        packet_active = 1'b1;
        idle(1);
    endtask

    task automatic check_flags(input string tag, input logic v, input logic [7:0] d,
                               input logic se, input logic ov);
        check_val({tag, "_valid"}, 32'(byte_valid), 32'(v));
        check_val({tag, "_data"}, 32'(rx_packet_data), 32'(d));
        check_val({tag, "_stuff"}, 32'(stuff_error), 32'(se));
        check_val({tag, "_ovr"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        n_rst         = 1'b0;
        rx_bit        = 1'b0;
        shift_strobe  = 1'b0;
        packet_active = 1'b0;
        byte_ack      = 1'b0;
        idle(2);
        check_flags("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("reset_partial", 32'(partial_byte), 32'd0);
        n_rst = 1'b1;
        idle(1);
        packet_active = 1'b1;
        idle(1);

        // 0xA5 MSB-first, valid one clock after the 8th strobe, cleared by ack
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(0);
        check_val("a5_not_yet", 32'(byte_valid), 32'd0);
        send_bit(1);
        check_flags("a5", 1'b1, 8'hA5, 1'b0, 1'b0);
        ack_byte();
        check_val("a5_acked", 32'(byte_valid), 32'd0);
        ack_byte();
        check_val("ack_idle_ignored", 32'(byte_valid), 32'd0);

        // 0xFF then 0xFC with a stuff 0 after each run of six 1s
        new_packet();
        for (int i = 0; i < 6; i++) send_bit(1);
        send_bit(0);
        send_bit(1);
        check_val("ff_stuff_not_counted", 32'(byte_valid), 32'd0);
        send_bit(1);
        check_flags("ff", 1'b1, 8'hFF, 1'b0, 1'b0);
        ack_byte();
        for (int i = 0; i < 4; i++) send_bit(1);
        send_bit(0);
        send_bit(1); send_bit(1); send_bit(0);
        check_val("fc_not_yet", 32'(byte_valid), 32'd0);
        send_bit(0);
        check_flags("fc", 1'b1, 8'hFC, 1'b0, 1'b0);
        ack_byte();

        // Six 1s then a 1 in the stuff slot: error, bit discarded, assembly continues
        new_packet();
        for (int i = 0; i < 6; i++) send_bit(1);
        send_bit(1);
        check_val("serr_set", 32'(stuff_error), 32'd1);
        check_val("serr_discard", 32'(byte_valid), 32'd0);
        send_bit(0);
        send_bit(1);
        check_flags("serr_byte", 1'b1, 8'hFD, 1'b1, 1'b0);
        ack_byte();
        packet_active = 1'b0;
        idle(1);
        check_val("serr_cleared", 32'(stuff_error), 32'd0);
        check_val("serr_no_partial", 32'(partial_byte), 32'd0);
        packet_active = 1'b1;
        idle(1);

        // 0x12 then 0x34 without ack: second byte dropped, overrun
        send_byte(8'h12, 1'b0);
        check_flags("ovr_first", 1'b1, 8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0);
        check_flags("ovr_second", 1'b1, 8'h12, 1'b0, 1'b1);
        packet_active = 1'b0;
        idle(1);
        check_flags("ovr_cleared", 1'b1, 8'h12, 1'b0, 1'b0);
        ack_byte();
        packet_active = 1'b1;
        idle(1);
        // Same pair with ack on the completion cycle: new byte loaded, no overrun
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        check_flags("ack_on_complete", 1'b1, 8'h34, 1'b0, 1'b0);
        ack_byte();
        check_val("ack_on_complete_done", 32'(byte_valid), 32'd0);

        // End of packet after 5 bits: partial pulse, held byte retained
        new_packet();
        send_byte(8'h5A, 1'b0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        packet_active = 1'b0;
        idle(1);
        check_val("partial_pulse", 32'(partial_byte), 32'd1);
        check_flags("partial_keep", 1'b1, 8'h5A, 1'b0, 1'b0);
        send_bit(1);
        check_val("partial_one_cycle", 32'(partial_byte), 32'd0);
        send_bit(1);
        packet_active = 1'b1;
        idle(1);
        ack_byte();
        send_byte(8'h3C, 1'b0);
        check_flags("after_partial", 1'b1, 8'h3C, 1'b0, 1'b0);
        check_val("after_partial_pulse", 32'(partial_byte), 32'd0);
        ack_byte();

        // Asynchronous reset mid-byte with a byte held
        new_packet();
        send_byte(8'h81, 1'b0);
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        check_val("pre_reset_valid", 32'(byte_valid), 32'd1);
        #3;
        n_rst = 1'b0;
        #1;
        check_flags("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(1);
        send_byte(8'hC3, 1'b0);
        check_flags("post_reset", 1'b1, 8'hC3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
